// File: rtl/poly_mac_accum.sv
// Accumulates NUM_TERMS product polynomials limb-wise modulo each q-basis prime,
// then holds the sum until downstream takes it.
module poly_mac_accum #(
    parameter int NUM_TERMS = 3,
    parameter int N_SLOTS   = 4,
    parameter int Q_LEN     = 2,
    parameter int LIMB_W    = 16,
    parameter logic [Q_LEN-1:0][LIMB_W-1:0] Q_BASIS = {16'd65521, 16'd12289}
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     clear,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [N_SLOTS-1:0][Q_LEN-1:0][LIMB_W-1:0] in_poly,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [N_SLOTS-1:0][Q_LEN-1:0][LIMB_W-1:0] out_poly,
    output logic [7:0]                               term_cnt
);

    typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

    localparam logic [7:0] LAST_CNT = 8'(NUM_TERMS - 1);

    state_t                                   state_q;
    logic [7:0]                               term_cnt_q;
    logic [N_SLOTS-1:0][Q_LEN-1:0][LIMB_W-1:0] acc_q;
    logic [N_SLOTS-1:0][Q_LEN-1:0][LIMB_W-1:0] acc_d;
    logic                                     in_fire;
    logic                                     out_fire;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_poly  = acc_q;
    assign term_cnt  = term_cnt_q;

    genvar gi, gj;
    generate
        for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
            for (gj = 0; gj < Q_LEN; gj++) begin : g_limb
                logic [LIMB_W:0]   sum;
                logic [LIMB_W-1:0] wrapped;

                assign sum     = {1'b0, acc_q[gi][gj]} + {1'b0, in_poly[gi][gj]};
                // Reduced result is always < q, so the low bits of sum - q are exact.
                assign wrapped = sum[LIMB_W-1:0] - Q_BASIS[gj];
                assign acc_d[gi][gj] = (term_cnt_q == 8'd0) ? in_poly[gi][gj]
                                     : (sum >= {1'b0, Q_BASIS[gj]}) ? wrapped
                                     : sum[LIMB_W-1:0];

                always_ff @(posedge clk) begin
                    if (reset) begin
                        acc_q[gi][gj] <= '0;
                    end else if (!clear && in_fire) begin
                        acc_q[gi][gj] <= acc_d[gi][gj];
                    end
                end
            end
        end
    endgenerate

    // Priority: reset, then clear, then the handshakes (mutually exclusive by state).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ACCUM;
            term_cnt_q <= 8'd0;
        end else if (clear) begin
            state_q    <= ACCUM;
            term_cnt_q <= 8'd0;
        end else if (in_fire) begin
            term_cnt_q <= term_cnt_q + 8'd1;
            if (term_cnt_q == LAST_CNT) begin
                state_q <= DONE;
            end
        end else if (out_fire) begin
            state_q    <= ACCUM;
            term_cnt_q <= 8'd0;
        end
    end

endmodule

// File: tb/tb_poly_mac_accum.sv
// Directed bench: a 3-term accumulator and a 1-term echo instance share clk/reset.
module tb_poly_mac_accum;

    typedef logic [3:0][1:0][15:0] poly_t;

    localparam logic [15:0] Q0 = 16'd12289;
    localparam logic [15:0] Q1 = 16'd65521;

    logic  clk = 1'b0;
    logic  reset, clear, in_valid, out_ready;
    logic  in_ready, out_valid;
    poly_t in_poly, out_poly;
    logic [7:0] term_cnt;

    logic  clear1, in_valid1, out_ready1;
    logic  in_ready1, out_valid1;
    poly_t in_poly1, out_poly1;
    logic [7:0] term_cnt1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    poly_mac_accum #(.NUM_TERMS(3)) u_dut3 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_poly(in_poly),
        .out_valid(out_valid), .out_ready(out_ready), .out_poly(out_poly),
        .term_cnt(term_cnt)
    );

    poly_mac_accum #(.NUM_TERMS(1)) u_dut1 (
        .clk(clk), .reset(reset), .clear(clear1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_poly(in_poly1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_poly(out_poly1),
        .term_cnt(term_cnt1)
    );

    function automatic poly_t fill(input logic [15:0] v0, input logic [15:0] v1);
        poly_t p;
        for (int s = 0; s < 4; s++) begin
            p[s][0] = v0;
            p[s][1] = v1;
        end
        return p;
    endfunction

    function automatic poly_t rand_poly();
        poly_t p;
        for (int s = 0; s < 4; s++) begin
            p[s][0] = 16'($urandom_range(0, 32'(Q0) - 1));
            p[s][1] = 16'($urandom_range(0, 32'(Q1) - 1));
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push3(input poly_t p);
        in_valid = 1'b1;
        in_poly  = p;
        step();
        in_valid = 1'b0;
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("out_hs_valid", 128'(out_valid), 128'(0));
        chk("out_hs_ready", 128'(in_ready), 128'(1));
        chk("out_hs_cnt",   128'(term_cnt), 128'(0));
    endtask

    initial begin
        poly_t p;
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_poly = '0;
        clear1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; in_poly1 = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_ready", 128'(in_ready), 128'(1));
        chk("rst_cnt",   128'(term_cnt), 128'(0));
        chk("rst_poly",  out_poly, 128'(0));
        $display("reset checked");

        // Three maximal limbs back-to-back: wraps twice to q-3.
        in_valid = 1'b1;
        in_poly  = fill(Q0 - 16'd1, Q1 - 16'd1);
        step();
        chk("max_cnt1", 128'(term_cnt), 128'(1));
        step();
        chk("max_cnt2",   128'(term_cnt), 128'(2));
        chk("max_valid2", 128'(out_valid), 128'(0));
        step();
        in_valid = 1'b0;
        chk("max_valid", 128'(out_valid), 128'(1));
        chk("max_ready", 128'(in_ready), 128'(0));
        chk("max_cnt3",  128'(term_cnt), 128'(3));
        chk("max_poly",  out_poly, fill(Q0 - 16'd3, Q1 - 16'd3));
        $display("txn max-limb sum: out_poly=%h", out_poly);
        take_out();

        // Terms 1,2,3 with two idle cycles between them.
        for (int k = 1; k <= 3; k++) begin
            push3(fill(16'(k), 16'(k)));
            if (k < 3) begin
                step(); step();
                chk("gap_cnt", 128'(term_cnt), 128'(k));
                chk("gap_ready", 128'(in_ready), 128'(1));
            end
        end
        chk("gap_valid", 128'(out_valid), 128'(1));
        chk("gap_ready_done", 128'(in_ready), 128'(0));
        chk("gap_poly", out_poly, fill(16'd6, 16'd6));
        $display("txn gapped sum: out_poly=%h", out_poly);

        // Back-pressure: result must stay put.
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_poly",  out_poly, fill(16'd6, 16'd6));
            chk("hold_valid", 128'(out_valid), 128'(1));
        end
        take_out();
        for (int k = 7; k <= 9; k++) push3(fill(16'(k), 16'(k)));
        chk("fresh_poly", out_poly, fill(16'd24, 16'd24));
        $display("txn fresh sum after stall: out_poly=%h", out_poly);
        take_out();

        // Clear mid-accumulation wins over a concurrent valid input.
        push3(fill(16'd5, 16'd5));
        push3(fill(16'd5, 16'd5));
        chk("pre_clear_cnt", 128'(term_cnt), 128'(2));
        clear = 1'b1;
        push3(fill(16'd100, 16'd100));
        clear = 1'b0;
        chk("clear_cnt",   128'(term_cnt), 128'(0));
        chk("clear_valid", 128'(out_valid), 128'(0));
        for (int k = 0; k < 3; k++) push3(fill(16'd5, 16'd5));
        chk("clear_sum", out_poly, fill(16'd15, 16'd15));
        $display("txn sum after clear: out_poly=%h", out_poly);

        // Clear while a result is pending discards it.
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_done_valid", 128'(out_valid), 128'(0));
        chk("clear_done_ready", 128'(in_ready), 128'(1));

        // Reset in DONE.
        for (int k = 0; k < 3; k++) push3(fill(16'd1, 16'd1));
        chk("pre_rst_valid", 128'(out_valid), 128'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_done_valid", 128'(out_valid), 128'(0));
        chk("rst_done_cnt",   128'(term_cnt), 128'(0));
        chk("rst_done_poly",  out_poly, 128'(0));
        $display("txn reset in DONE");

        // Reset mid-accumulation.
        push3(fill(16'd4, 16'd4));
        chk("mid_poly", out_poly, fill(16'd4, 16'd4));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_cnt",  128'(term_cnt), 128'(0));
        chk("rst_mid_poly", out_poly, 128'(0));
        $display("txn reset mid-ACCUM");

        // Single-term instance echoes each poly, one result every two cycles.
        out_ready1 = 1'b1;
        in_valid1  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            p = rand_poly();
            in_poly1 = p;
            step();
            chk("echo_valid", 128'(out_valid1), 128'(1));
            chk("echo_ready", 128'(in_ready1), 128'(0));
            chk("echo_poly",  out_poly1, p);
            step();
            chk("echo_idle_valid", 128'(out_valid1), 128'(0));
            chk("echo_idle_cnt",   128'(term_cnt1), 128'(0));
            $display("txn echo %0d: out_poly=%h", k, out_poly1);
        end
        in_valid1 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
